yarp_mem_arbiter: RTL and testbench

Multi-cycle memory front end that sits directly below the yarp core's instruction and data memory ports and serialises them onto one shared request/grant/response bus. Per retired instruction it performs one fetch, then an optional data access. It holds the core with `stall_o` until both have completed, and returns captured read data on stable registers. It converts the single-cycle core into one that runs against wait-stated memory.

---
 rtl/yarp_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_yarp_mem_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_mem_arbiter.sv
// Serialises the yarp core's fetch and data ports onto one request/grant/response bus.
// Optional bus timeout is enabled by defining YARP_ARB_TIMEOUT_EN.
module yarp_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  // Core instruction port
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rd_data_o,
  // Core data port
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic [31:0] data_rd_data_o,
  // Core control
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  // Shared memory bus
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StIReq,
    StIWait,
    StDChk,
    StDReq,
    StDWait,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic        req_q, req_d;
  logic        stall_q, stall_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        timeout;
  logic        data_misaligned;

  // Word needs addr[1:0]==0, half needs addr[0]==0; bytes are always aligned.
  assign data_misaligned = ((data_byte_en_i == 2'b11) && (data_addr_i[1:0] != 2'b00)) ||
                           ((data_byte_en_i == 2'b01) && data_addr_i[0]);

`ifdef YARP_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_bus;

  assign in_bus  = (state_q == StIReq) || (state_q == StIWait) ||
                   (state_q == StDReq) || (state_q == StDWait);
  assign timeout = in_bus && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  // Restart on every state change so each bus phase gets the full budget.
  assign cnt_d   = (in_bus && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wr_d       = wr_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    if (timeout) begin
      bus_err_d = 1'b1;
      if ((state_q == StIReq) || (state_q == StIWait)) begin
        instr_d = ErrData;
        state_d = StDChk;
      end else begin
        if (!wr_q) begin
          rdata_d = ErrData;
        end
        state_d = StDone;
      end
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (instr_req_i) begin
            addr_d  = instr_addr_i;
            wr_d    = 1'b0;
            be_d    = 2'b11;
            wdata_d = '0;
            state_d = StIReq;
          end else begin
            state_d = StIdle;
          end
        end
        StIReq: begin
          if (mem_gnt_i) begin
            state_d = StIWait;
          end
        end
        StIWait: begin
          if (mem_rvalid_i) begin
            instr_d = mem_rdata_i;
            state_d = StDChk;
          end
        end
        StDChk: begin
          if (data_req_i && data_misaligned) begin
            misalign_d = 1'b1;
            state_d    = StDone;
          end else if (data_req_i) begin
            addr_d  = data_addr_i;
            wr_d    = data_wr_i;
            be_d    = data_byte_en_i;
            wdata_d = data_wr_data_i;
            state_d = StDReq;
          end else begin
            state_d = StDone;
          end
        end
        StDReq: begin
          if (mem_gnt_i) begin
            state_d = StDWait;
          end
        end
        StDWait: begin
          if (mem_rvalid_i) begin
            if (!wr_q) begin
              rdata_d = mem_rdata_i;
            end
            state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    req_d   = (state_d == StIReq) || (state_d == StDReq);
    stall_d = (state_d != StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wr_q       <= 1'b0;
      req_q      <= 1'b0;
      instr_q    <= '0;
      rdata_q    <= '0;
      stall_q    <= 1'b1;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wr_q       <= wr_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
      stall_q    <= stall_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign instr_rd_data_o = instr_q;
  assign data_rd_data_o  = rdata_q;
  assign stall_o         = stall_q;
  assign misalign_o      = misalign_q;
  assign bus_err_o       = bus_err_q;
  assign mem_req_o       = req_q;
  assign mem_addr_o      = addr_q;
  assign mem_wr_o        = wr_q;
  assign mem_byte_en_o   = be_q;
  assign mem_wr_data_o   = wdata_q;

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Directed self-checking bench for yarp_mem_arbiter: fetch, load, store, misalign,
// back-to-back, mid-transaction reset and (with YARP_ARB_TIMEOUT_EN) bus timeout.
module tb_yarp_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rd_data_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [1:0]  data_byte_en_i;
  logic        data_wr_i;
  logic [31:0] data_wr_data_i;
  logic [31:0] data_rd_data_o;
  logic        stall_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_wr_o;
  logic [1:0]  mem_byte_en_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int total;
  int bad;

  yarp_mem_arbiter #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_rd_data_o(instr_rd_data_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_byte_en_i (data_byte_en_i),
    .data_wr_i      (data_wr_i),
    .data_wr_data_i (data_wr_data_i),
    .data_rd_data_o (data_rd_data_o),
    .stall_o        (stall_o),
    .misalign_o     (misalign_o),
    .bus_err_o      (bus_err_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_o       (mem_wr_o),
    .mem_byte_en_o  (mem_byte_en_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as core + bus for one instruction. Cycle 1 is the first cycle after the
  // request is sampled; returns at #1 into the first cycle with stall_o low (-1 if never).
  task automatic run_txn(input int i_dly, input int d_dly, input logic [31:0] irdata,
                         input logic [31:0] drdata, output int done_cyc,
                         output bit first_req, output logic [31:0] i_addr,
                         output int unstable, output int proto, output bit d_seen,
                         output logic [31:0] d_addr, output logic d_wr,
                         output logic [1:0] d_be, output logic [31:0] d_wdata,
                         output int mis_cnt, output bit mis_done);
    int          req_cnt;
    bit          phase;
    bit          rv_next;
    logic [66:0] hold;
    logic [66:0] cur;
    done_cyc  = -1;
    first_req = 1'b0;
    i_addr    = '0;
    unstable  = 0;
    proto     = 0;
    d_seen    = 1'b0;
    d_addr    = '0;
    d_wr      = 1'b0;
    d_be      = '0;
    d_wdata   = '0;
    mis_cnt   = 0;
    mis_done  = 1'b0;
    req_cnt   = 0;
    phase     = 1'b0;
    rv_next   = 1'b0;
    hold      = '0;
    instr_req_i = 1'b1;
    tick();
    instr_req_i = 1'b0;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (c == 1) begin
        first_req = mem_req_o;
        i_addr    = mem_addr_o;
      end
      if (misalign_o) mis_cnt++;
      cur = {mem_addr_o, mem_wr_o, mem_byte_en_o, mem_wr_data_o};
      if (!stall_o) begin
        done_cyc = c;
        mis_done = misalign_o;
      end else if (rv_next) begin
        if (mem_req_o) proto++;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = phase ? drdata : irdata;
        rv_next      = 1'b0;
        phase        = 1'b1;
      end else if (mem_req_o) begin
        if (phase && !d_seen) begin
          d_seen  = 1'b1;
          d_addr  = mem_addr_o;
          d_wr    = mem_wr_o;
          d_be    = mem_byte_en_o;
          d_wdata = mem_wr_data_o;
        end
        if (req_cnt == 0) hold = cur;
        else if (cur !== hold) unstable++;
        if (req_cnt == (phase ? d_dly : i_dly)) begin
          mem_gnt_i = 1'b1;
          rv_next   = 1'b1;
          req_cnt   = 0;
        end else begin
          req_cnt++;
        end
      end
      if (done_cyc < 0) tick();
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic set_data(input bit req, input logic [31:0] addr, input logic [1:0] be,
                          input bit wr, input logic [31:0] wdata);
    data_req_i     = req;
    data_addr_i    = addr;
    data_byte_en_i = be;
    data_wr_i      = wr;
    data_wr_data_i = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (stall_o !== 1'b1) begin
      bad++; $display("FAIL reset_stall: got %b want 1", stall_o);
    end
    total++;
    if ({mem_req_o, mem_addr_o, mem_wr_o, mem_byte_en_o, mem_wr_data_o} !== 67'd0) begin
      bad++; $display("FAIL reset_mem: got req=%b addr=%h wr=%b be=%b wd=%h want all 0",
                      mem_req_o, mem_addr_o, mem_wr_o, mem_byte_en_o, mem_wr_data_o);
    end
    total++;
    if ({instr_rd_data_o, data_rd_data_o, misalign_o, bus_err_o} !== 66'd0) begin
      bad++; $display("FAIL reset_data: got i=%h d=%h mis=%b err=%b want all 0",
                      instr_rd_data_o, data_rd_data_o, misalign_o, bus_err_o);
    end
    reset = 1'b0;
    tick();
    total++;
    if ({stall_o, mem_req_o} !== 2'b10) begin
      bad++; $display("FAIL idle_after_reset: got stall=%b req=%b want 1 0", stall_o, mem_req_o);
    end
  endtask

  task automatic test_fetch();
    int done; bit fr; logic [31:0] ia; int uns; int pr; bit ds;
    logic [31:0] da; logic dw; logic [1:0] db; logic [31:0] dwd; int mc; bit md;
    set_data(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    instr_addr_i = 32'h0000_1000;
    run_txn(0, 0, 32'h0000_0013, 32'h0, done, fr, ia, uns, pr, ds, da, dw, db, dwd, mc, md);
    total++;
    if ({fr, ia} !== {1'b1, 32'h0000_1000}) begin
      bad++; $display("FAIL fetch_req: got req=%b addr=%h want 1 00001000", fr, ia);
    end
    total++;
    if (done !== 4) begin
      bad++; $display("FAIL fetch_latency: got %0d want 4", done);
    end
    total++;
    if (instr_rd_data_o !== 32'h0000_0013) begin
      bad++; $display("FAIL fetch_data: got %h want 00000013", instr_rd_data_o);
    end
    total++;
    if ({uns, pr, ds} !== {32'd0, 32'd0, 1'b0}) begin
      bad++; $display("FAIL fetch_proto: got unstable=%0d proto=%0d dreq=%b want 0 0 0",
                      uns, pr, ds);
    end
    tick();
    total++;
    if (stall_o !== 1'b1) begin
      bad++; $display("FAIL fetch_stall_one_cycle: got %b want 1", stall_o);
    end
  endtask

  task automatic test_load();
    int done; bit fr; logic [31:0] ia; int uns; int pr; bit ds;
    logic [31:0] da; logic dw; logic [1:0] db; logic [31:0] dwd; int mc; bit md;
    set_data(1'b1, 32'h0000_2004, 2'b11, 1'b0, 32'h0);
    instr_addr_i = 32'h0000_1004;
    run_txn(0, 3, 32'h0040_2003, 32'hCAFE_F00D, done, fr, ia, uns, pr, ds, da, dw, db, dwd,
            mc, md);
    total++;
    if (done !== 9) begin
      bad++; $display("FAIL load_latency: got %0d want 9", done);
    end
    total++;
    if (data_rd_data_o !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL load_data: got %h want cafef00d", data_rd_data_o);
    end
    total++;
    if ({ds, da, dw, db} !== {1'b1, 32'h0000_2004, 1'b0, 2'b11}) begin
      bad++; $display("FAIL load_bus: got seen=%b addr=%h wr=%b be=%b want 1 00002004 0 11",
                      ds, da, dw, db);
    end
    total++;
    if ({uns, pr} !== {32'd0, 32'd0}) begin
      bad++; $display("FAIL load_stable: got unstable=%0d proto=%0d want 0 0", uns, pr);
    end
    tick();
  endtask

  task automatic test_store();
    int done; bit fr; logic [31:0] ia; int uns; int pr; bit ds;
    logic [31:0] da; logic dw; logic [1:0] db; logic [31:0] dwd; int mc; bit md;
    set_data(1'b1, 32'h0000_2002, 2'b01, 1'b1, 32'h0000_1234);
    instr_addr_i = 32'h0000_1008;
    run_txn(0, 1, 32'h0041_1123, 32'hFFFF_FFFF, done, fr, ia, uns, pr, ds, da, dw, db, dwd,
            mc, md);
    total++;
    if ({ds, da, dw, db, dwd} !== {1'b1, 32'h0000_2002, 1'b1, 2'b01, 32'h0000_1234}) begin
      bad++; $display("FAIL store_bus: got seen=%b addr=%h wr=%b be=%b wd=%h want 1 00002002 1 01 00001234",
                      ds, da, dw, db, dwd);
    end
    total++;
    if (data_rd_data_o !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL store_rdata_kept: got %h want cafef00d", data_rd_data_o);
    end
    total++;
    if ({done, uns, pr} !== {32'd7, 32'd0, 32'd0}) begin
      bad++; $display("FAIL store_latency: got done=%0d unstable=%0d proto=%0d want 7 0 0",
                      done, uns, pr);
    end
    tick();
  endtask

  task automatic test_misalign();
    int done; bit fr; logic [31:0] ia; int uns; int pr; bit ds;
    logic [31:0] da; logic dw; logic [1:0] db; logic [31:0] dwd; int mc; bit md;
    set_data(1'b1, 32'h0000_2001, 2'b11, 1'b0, 32'h0);
    instr_addr_i = 32'h0000_100C;
    run_txn(0, 0, 32'h0010_2083, 32'h5555_5555, done, fr, ia, uns, pr, ds, da, dw, db, dwd,
            mc, md);
    total++;
    if ({done, ds, mc, md} !== {32'd4, 1'b0, 32'd1, 1'b1}) begin
      bad++; $display("FAIL mis_word: got done=%0d dreq=%b pulses=%0d in_done=%b want 4 0 1 1",
                      done, ds, mc, md);
    end
    tick();
    total++;
    if (misalign_o !== 1'b0) begin
      bad++; $display("FAIL mis_pulse_width: got %b want 0", misalign_o);
    end
    set_data(1'b1, 32'h0000_2003, 2'b01, 1'b1, 32'h0000_00AA);
    run_txn(0, 0, 32'h0010_1023, 32'h5555_5555, done, fr, ia, uns, pr, ds, da, dw, db, dwd,
            mc, md);
    total++;
    if ({done, ds, mc} !== {32'd4, 1'b0, 32'd1}) begin
      bad++; $display("FAIL mis_half: got done=%0d dreq=%b pulses=%0d want 4 0 1", done, ds, mc);
    end
    tick();
    set_data(1'b1, 32'h0000_2003, 2'b00, 1'b0, 32'h0);
    run_txn(0, 0, 32'h0030_0003, 32'h0000_00AB, done, fr, ia, uns, pr, ds, da, dw, db, dwd,
            mc, md);
    total++;
    if ({done, ds, mc, da} !== {32'd6, 1'b1, 32'd0, 32'h0000_2003}) begin
      bad++; $display("FAIL byte_aligned: got done=%0d dreq=%b pulses=%0d addr=%h want 6 1 0 00002003",
                      done, ds, mc, da);
    end
    total++;
    if (data_rd_data_o !== 32'h0000_00AB) begin
      bad++; $display("FAIL byte_data: got %h want 000000ab", data_rd_data_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int done; bit fr; logic [31:0] ia; int uns; int pr; bit ds;
    logic [31:0] da; logic dw; logic [1:0] db; logic [31:0] dwd; int mc; bit md;
    set_data(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    instr_addr_i = 32'h0000_1100;
    run_txn(0, 0, 32'h0000_0001, 32'h0, done, fr, ia, uns, pr, ds, da, dw, db, dwd, mc, md);
    total++;
    if (done !== 4) begin
      bad++; $display("FAIL b2b_first: got %0d want 4", done);
    end
    // Still in the retire cycle: the next fetch must go straight to the bus.
    instr_addr_i = 32'h0000_1104;
    run_txn(0, 0, 32'h0000_0002, 32'h0, done, fr, ia, uns, pr, ds, da, dw, db, dwd, mc, md);
    total++;
    if ({fr, ia, done} !== {1'b1, 32'h0000_1104, 32'd4}) begin
      bad++; $display("FAIL b2b_second: got req=%b addr=%h done=%0d want 1 00001104 4",
                      fr, ia, done);
    end
    total++;
    if (instr_rd_data_o !== 32'h0000_0002) begin
      bad++; $display("FAIL b2b_data: got %h want 00000002", instr_rd_data_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int done; bit fr; logic [31:0] ia; int uns; int pr; bit ds;
    logic [31:0] da; logic dw; logic [1:0] db; logic [31:0] dwd; int mc; bit md;
    set_data(1'b1, 32'h0000_2008, 2'b11, 1'b0, 32'h0);
    instr_addr_i = 32'h0000_1010;
    instr_req_i  = 1'b1;
    tick();
    instr_req_i  = 1'b0;
    mem_gnt_i    = 1'b1;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_1111;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    total++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_2008}) begin
      bad++; $display("FAIL mid_dreq: got req=%b addr=%h want 1 00002008", mem_req_o, mem_addr_o);
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({stall_o, mem_req_o, mem_addr_o, instr_rd_data_o, data_rd_data_o} !== {2'b10, 96'd0})
    begin
      bad++; $display("FAIL mid_async_reset: got stall=%b req=%b addr=%h i=%h d=%h want 1 0 0 0 0",
                      stall_o, mem_req_o, mem_addr_o, instr_rd_data_o, data_rd_data_o);
    end
    tick();
    reset        = 1'b0;
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBADB_AD00;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    total++;
    if ({stall_o, mem_req_o, data_rd_data_o, instr_rd_data_o} !== {2'b10, 64'd0}) begin
      bad++; $display("FAIL mid_late_rvalid: got stall=%b req=%b d=%h i=%h want 1 0 0 0",
                      stall_o, mem_req_o, data_rd_data_o, instr_rd_data_o);
    end
    instr_addr_i = 32'h0000_1200;
    run_txn(0, 0, 32'h0000_0013, 32'h0, done, fr, ia, uns, pr, ds, da, dw, db, dwd, mc, md);
    total++;
    if ({fr, ia, done, instr_rd_data_o} !== {1'b1, 32'h0000_1200, 32'd4, 32'h0000_0013}) begin
      bad++; $display("FAIL mid_refetch: got req=%b addr=%h done=%0d i=%h want 1 00001200 4 00000013",
                      fr, ia, done, instr_rd_data_o);
    end
    tick();
  endtask

`ifdef YARP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int err_cyc;
    err_cyc = -1;
    set_data(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    instr_addr_i = 32'h0000_1300;
    instr_req_i  = 1'b1;
    tick();
    instr_req_i  = 1'b0;
    for (int c = 1; c <= 40 && err_cyc < 0; c++) begin
      if (bus_err_o) err_cyc = c;
      else tick();
    end
    total++;
    if (err_cyc !== 17) begin
      bad++; $display("FAIL timeout_cycle: got %0d want 17", err_cyc);
    end
    total++;
    if ({mem_req_o, instr_rd_data_o} !== {1'b0, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL timeout_data: got req=%b i=%h want 0 deadbeef",
                      mem_req_o, instr_rd_data_o);
    end
    tick();
    tick();
    tick();
  endtask
`endif

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    instr_req_i    = 1'b0;
    instr_addr_i   = '0;
    data_req_i     = 1'b0;
    data_addr_i    = '0;
    data_byte_en_i = '0;
    data_wr_i      = 1'b0;
    data_wr_data_i = '0;
    mem_gnt_i      = 1'b0;
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
`ifdef YARP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
